// File: rtl/mole_spawner_pkg.sv
// Shared definitions for the whac-a-mole mole spawner: board size,
// level type, display width, LFSR constants and default hit windows.
package whac_pkg;

  localparam int NUM_MOLES = 18;
  localparam int MS_W      = 11;

  typedef logic [1:0] level_t;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Default hit window in ms for each level; level 0 plays like level 1.
  function automatic int win_ms(input level_t lvl);
    case (lvl)
      2'd2:    return 1000;
      2'd3:    return 500;
      default: return 1500;
    endcase
  endfunction

endpackage

// File: rtl/mole_spawner_if.sv
// Link between the game FSM (master) and the mole spawner (slave):
// FSM requests/levels one way, mole selection and window status back.
interface mole_spawner_if;
  import whac_pkg::*;

  logic                   ready_for_mole;
  logic                   timeout_start;
  level_t                 level_number;
  logic [NUM_MOLES-1:0]   led_number;
  logic [4:0]             mole_index;
  logic                   timeout;
  logic [MS_W-1:0]        time_left_ms;

  modport master (
    output ready_for_mole, timeout_start, level_number,
    input  led_number, mole_index, timeout, time_left_ms
  );

  modport slave (
    input  ready_for_mole, timeout_start, level_number,
    output led_number, mole_index, timeout, time_left_ms
  );

endinterface

// File: rtl/mole_spawner_lfsr.sv
// 16-bit Galois LFSR used as the free-running entropy source for mole
// selection. An all-zero seed would lock up, so it is swapped for the
// default seed.
module lfsr16
  import whac_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] seed_eff;

  assign seed_eff = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;

  // Advance every cycle; shift right and fold the mask in when bit 0 falls out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= seed_eff;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
    end
  end

endmodule

// File: rtl/mole_spawner.sv
// Mole spawner: picks a non-repeating pseudo-random mole on each request
// and runs the level-dependent hit window while the FSM waits for a hit.
// Optional feature macro: MOLE_SPEEDUP_EN (window shrinks with each spawn
// down to a floor; reloaded when the level changes between spawns).
module mole_spawner
  import whac_pkg::*;
#(
  parameter int          CLK_HZ     = 50_000_000,
  parameter logic [15:0] LFSR_SEED  = LFSR_DEFAULT_SEED,
`ifdef MOLE_SPEEDUP_EN
  parameter int          SPEEDUP_MS = 20,
  parameter int          MIN_WIN_MS = 250,
`endif
  parameter int          WIN_L1_MS  = win_ms(2'd1),
  parameter int          WIN_L2_MS  = win_ms(2'd2),
  parameter int          WIN_L3_MS  = win_ms(2'd3)
) (
  input  logic          clk,
  input  logic          reset,
  mole_spawner_if.slave bus
);

  localparam int TICKS = CLK_HZ / 1000;
  localparam int PS_W  = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'((TICKS > 0) ? TICKS - 1 : 0);
  localparam logic [4:0] MOLES     = 5'(NUM_MOLES);
  localparam logic [4:0] LAST_MOLE = 5'(NUM_MOLES - 1);

  function automatic logic [MS_W-1:0] level_win(input level_t lvl);
    case (lvl)
      2'd2:    return MS_W'(WIN_L2_MS);
      2'd3:    return MS_W'(WIN_L3_MS);
      default: return MS_W'(WIN_L1_MS);
    endcase
  endfunction

  logic [15:0]          lfsr_q;
  logic                 unused_lfsr_bits;
  logic [4:0]           cand_fold;
  logic [4:0]           cand;
  logic [NUM_MOLES-1:0] led_q;
  logic [4:0]           idx_q;
  logic                 timeout_q;
  logic [MS_W-1:0]      time_left_q;
  logic                 ts_q;
  logic [PS_W-1:0]      presc;
  logic [MS_W-1:0]      arm_win;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign unused_lfsr_bits = ^lfsr_q[15:5];

  assign bus.led_number   = led_q;
  assign bus.mole_index   = idx_q;
  assign bus.timeout      = timeout_q;
  assign bus.time_left_ms = time_left_q;

  // Fold the 5 LFSR bits into 0..17 and step past the current mole so a
  // mole never appears twice in a row.
  always_comb begin
    cand_fold = lfsr_q[4:0];
    cand      = 5'd0;
    if (lfsr_q[4:0] >= MOLES) begin
      cand_fold = lfsr_q[4:0] - MOLES;
    end
    if (cand_fold == idx_q) begin
      cand = (cand_fold == LAST_MOLE) ? 5'd0 : cand_fold + 5'd1;
    end else begin
      cand = cand_fold;
    end
  end

  // Capture the new mole on each request; it holds until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= 5'd0;
      led_q <= '0;
    end else if (bus.ready_for_mole) begin
      idx_q <= cand;
      led_q <= NUM_MOLES'(1) << cand;
    end
  end

`ifdef MOLE_SPEEDUP_EN
  logic            loaded;
  level_t          lvl_latched;
  logic [MS_W-1:0] cur_win;
  logic [MS_W-1:0] spd_base;
  logic [MS_W-1:0] spd_next;

  // Pick the window the next spawn shrinks from, then apply the floor.
  always_comb begin
    spd_base = cur_win;
    spd_next = MS_W'(MIN_WIN_MS);
    if (!loaded || (bus.level_number != lvl_latched)) begin
      spd_base = level_win(bus.level_number);
    end
    if (int'(spd_base) >= MIN_WIN_MS + SPEEDUP_MS) begin
      spd_next = spd_base - MS_W'(SPEEDUP_MS);
    end
  end

  // Each spawn tightens the running window and remembers its level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loaded      <= 1'b0;
      lvl_latched <= 2'd0;
      cur_win     <= '0;
    end else if (bus.ready_for_mole) begin
      loaded      <= 1'b1;
      lvl_latched <= bus.level_number;
      cur_win     <= spd_next;
    end
  end

  assign arm_win = loaded ? cur_win : level_win(bus.level_number);
`else
  assign arm_win = level_win(bus.level_number);
`endif

  // Arm on the rising edge of timeout_start, count down once per ms while
  // it stays high, and flag expiry one cycle after reaching zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q        <= 1'b0;
      presc       <= '0;
      time_left_q <= '0;
      timeout_q   <= 1'b1;
    end else begin
      ts_q <= bus.timeout_start;
      if (!bus.timeout_start) begin
        timeout_q <= 1'b1;
        presc     <= '0;
      end else if (!ts_q) begin
        time_left_q <= arm_win;
        presc       <= '0;
        timeout_q   <= 1'b1;
      end else begin
        if (presc == PS_LAST) begin
          presc <= '0;
          if (time_left_q != '0) begin
            time_left_q <= time_left_q - MS_W'(1);
          end
        end else begin
          presc <= presc + PS_W'(1);
        end
        if (time_left_q == '0) begin
          timeout_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// Randomized bench for mole_spawner. Stimulus episodes push expected
// events into queues from a behavioural model; a negedge monitor pops and
// compares whenever an output changes. Honours MOLE_SPEEDUP_EN.
module tb_mole_spawner;
  import whac_pkg::*;

  localparam int          CLK_HZ  = 4000;
  localparam int          TICKS   = 4;
  localparam int          W1      = 5;
  localparam int          W2      = 3;
  localparam int          W3      = 2;
  localparam int          SPEEDUP = 1;
  localparam int          MIN_WIN = 3;
  localparam logic [15:0] SEED    = 16'hACE1;

  typedef struct {
    int value;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] zero_q;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  exp_t spawn_q[$];
  exp_t tl_q[$];
  exp_t to_q[$];

  logic [15:0] m_lfsr;
  int          m_idx;
  int          m_tl;
  int          m_cur;
  int          m_lvl_latched;
  bit          m_loaded;
  int          lvl_now;

  logic [NUM_MOLES-1:0] prev_led;
  logic [MS_W-1:0]      prev_tl;
  logic                 prev_to;

  mole_spawner_if bus();

  mole_spawner #(
    .CLK_HZ     (CLK_HZ),
    .LFSR_SEED  (SEED),
`ifdef MOLE_SPEEDUP_EN
    .SPEEDUP_MS (SPEEDUP),
    .MIN_WIN_MS (MIN_WIN),
`endif
    .WIN_L1_MS  (W1),
    .WIN_L2_MS  (W2),
    .WIN_L3_MS  (W3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  lfsr16 u_zero_seed (
    .clk   (clk),
    .reset (reset),
    .seed  (16'h0000),
    .q     (zero_q)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int win_of(input int lvl);
    if (lvl == 2) return W2;
    if (lvl == 3) return W3;
    return W1;
  endfunction

  always #5 clk = ~clk;

  // Cycle stamp shared by stimulus and monitor.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference sequence of the free-running random source.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic check_output(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag_unexpected(input string name, input int act);
    total++;
    bad++;
    $display("[TB] FAIL %s actual=%0d required=no_event (cycle %0d)", name, act, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int armed_window();
`ifdef MOLE_SPEEDUP_EN
    return m_loaded ? m_cur : win_of(lvl_now);
`else
    return win_of(lvl_now);
`endif
  endfunction

  // Model of a spawn requested in the current cycle.
  task automatic model_spawn();
    exp_t e;
    int   c;
    c = int'(m_lfsr[4:0]);
    if (c >= NUM_MOLES) c = c - NUM_MOLES;
    if (c == m_idx) c = (c + 1) % NUM_MOLES;
    m_idx   = c;
    e.value = c;
    e.cyc   = cyc + 1;
    spawn_q.push_back(e);
`ifdef MOLE_SPEEDUP_EN
    begin
      int base;
      if (!m_loaded || lvl_now != m_lvl_latched) base = win_of(lvl_now);
      else base = m_cur;
      m_cur = (base - SPEEDUP > MIN_WIN) ? base - SPEEDUP : MIN_WIN;
      m_loaded = 1'b1;
      m_lvl_latched = lvl_now;
    end
`endif
  endtask

  task automatic push_exp(input int which, input int value, input int at);
    exp_t e;
    e.value = value;
    e.cyc   = at;
    if (which == 0) tl_q.push_back(e);
    else            to_q.push_back(e);
  endtask

  // One game round: optional spawn, arm, hold for 'hold' cycles with
  // optional random spawns/level changes, then drop or reset.
  task automatic apply_stimulus(input int lvl, input int hold, input bit pre_spawn,
                                input bit mid_changes, input bit reset_at_end);
    int k;
    int w;
    int d;
    int lim;
    bus.ready_for_mole = 1'b0;
    lvl_now = lvl;
    bus.level_number = level_t'(lvl);
    if (pre_spawn) begin
      bus.ready_for_mole = 1'b1;
      model_spawn();
      step();
      bus.ready_for_mole = 1'b0;
    end
    step();
    k = cyc;
    bus.timeout_start = 1'b1;
    w = armed_window();
    d = k + hold;
    lim = reset_at_end ? d - 1 : d;
    if (w != m_tl) push_exp(0, w, k + 1);
    m_tl = w;
    for (int m = 1; m <= w; m++) begin
      if (k + 1 + TICKS * m <= lim) begin
        push_exp(0, w - m, k + 1 + TICKS * m);
        m_tl = w - m;
      end
    end
    if (k + 2 + TICKS * w <= lim) begin
      push_exp(1, 0, k + 2 + TICKS * w);
      if (!reset_at_end) push_exp(1, 1, d + 1);
    end
    for (int j = 1; j <= hold; j++) begin
      step();
      bus.ready_for_mole = 1'b0;
      if (mid_changes) begin
        if ($urandom_range(0, 4) == 0) begin
          lvl_now = int'($urandom_range(0, 3));
          bus.level_number = level_t'(lvl_now);
        end
        if ($urandom_range(0, 5) == 0 && !(reset_at_end && j >= hold - 1)) begin
          bus.ready_for_mole = 1'b1;
          model_spawn();
        end
      end
      if (j == hold && !reset_at_end) bus.timeout_start = 1'b0;
    end
    if (reset_at_end) begin
      reset = 1'b1;
      bus.timeout_start = 1'b0;
      bus.ready_for_mole = 1'b0;
      #1;
      check_output("midreset_led", int'(bus.led_number), 0);
      check_output("midreset_idx", int'(bus.mole_index), 0);
      check_output("midreset_timeout", int'(bus.timeout), 1);
      check_output("midreset_time_left", int'(bus.time_left_ms), 0);
      m_idx = 0;
      m_tl = 0;
      m_loaded = 1'b0;
      m_lvl_latched = 0;
      step();
      reset = 1'b0;
    end else begin
      step();
      bus.ready_for_mole = 1'b0;
    end
  endtask

  // Monitor: every observed output change must match the next queued event.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_led = bus.led_number;
      prev_tl  = bus.time_left_ms;
      prev_to  = bus.timeout;
    end else begin
      if (bus.led_number != prev_led) begin
        if (spawn_q.size() == 0) begin
          flag_unexpected("spawn_event", int'(bus.mole_index));
        end else begin
          e = spawn_q.pop_front();
          check_output("spawn_idx", int'(bus.mole_index), e.value);
          check_output("spawn_led", int'(bus.led_number), 1 << e.value);
          check_output("spawn_cycle", cyc, e.cyc);
        end
      end
      if (bus.time_left_ms != prev_tl) begin
        if (tl_q.size() == 0) begin
          flag_unexpected("time_left_event", int'(bus.time_left_ms));
        end else begin
          e = tl_q.pop_front();
          check_output("time_left_value", int'(bus.time_left_ms), e.value);
          check_output("time_left_cycle", cyc, e.cyc);
        end
      end
      if (bus.timeout != prev_to) begin
        if (to_q.size() == 0) begin
          flag_unexpected("timeout_event", int'(bus.timeout));
        end else begin
          e = to_q.pop_front();
          check_output("timeout_value", int'(bus.timeout), e.value);
          check_output("timeout_cycle", cyc, e.cyc);
        end
      end
      prev_led = bus.led_number;
      prev_tl  = bus.time_left_ms;
      prev_to  = bus.timeout;
    end
  end

  // Main sequence: reset checks, directed rounds, random rounds, mid-window reset.
  initial begin
    bus.ready_for_mole = 1'b0;
    bus.timeout_start  = 1'b0;
    bus.level_number   = 2'd0;
    reset = 1'b1;
    lvl_now = 0;
    m_idx = 0;
    m_tl = 0;
    m_cur = 0;
    m_loaded = 1'b0;
    m_lvl_latched = 0;
    repeat (3) step();
    check_output("reset_led", int'(bus.led_number), 0);
    check_output("reset_idx", int'(bus.mole_index), 0);
    check_output("reset_timeout", int'(bus.timeout), 1);
    check_output("reset_time_left", int'(bus.time_left_ms), 0);
    check_output("reset_lfsr", int'(dut.u_lfsr.q), 16'hACE1);
    check_output("zero_seed_lfsr", int'(zero_q), 16'hACE1);
    reset = 1'b0;

    $display("[TB] directed rounds");
    apply_stimulus(3, TICKS * W3 + 6, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2, TICKS + 1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(2, 3, 1'b0, 1'b0, 1'b0);
    apply_stimulus(0, TICKS * W1 + 3, 1'b1, 1'b0, 1'b0);

    $display("[TB] random rounds");
    for (int n = 0; n < 60; n++) begin
      apply_stimulus(int'($urandom_range(0, 3)), int'($urandom_range(1, TICKS * W1 + 8)),
                     1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    $display("[TB] reset mid-window");
    apply_stimulus(1, 7, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) begin
      apply_stimulus(int'($urandom_range(0, 3)), int'($urandom_range(1, TICKS * W1 + 8)),
                     1'b1, 1'b1, 1'b0);
    end

    repeat (6) step();
    check_output("spawn_pending", spawn_q.size(), 0);
    check_output("time_left_pending", tl_q.size(), 0);
    check_output("timeout_pending", to_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
